// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and default settle time.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package boot_loader_ctrl_pkg;

  typedef logic [1:0] state_t;

  // Binary state encoding kept as plain constants so older tools and dumps read it directly.
  localparam state_t ST_HALT   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;
  localparam state_t ST_RUN    = 2'd3;

  // Cycles between the last RAM write and core release, so the write lands before fetch.
  localparam int HOLD_DEFAULT = 2;

  // A download is in flight (either taking words or letting the last write settle).
  function automatic logic is_busy(input state_t s);
    return (s == ST_LOAD) || (s == ST_SETTLE);
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_settle_counter.sv
// Settle timer: down-counter armed on the last download word, terminal flag at zero.
// Latency: tc asserts on the HOLD-th cycle of counting after start (start loads HOLD-1).
// Backpressure: none; counts only while en is high, holds otherwise.
module settle_counter
  import boot_loader_ctrl_pkg::*;
#(
  parameter int HOLD = HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic tc
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [CW-1:0] cnt;

  // Arm with HOLD-1 so that the count-0 cycle is the last of exactly HOLD settle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(HOLD - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader: streams a program image into instruction RAM, then releases the core.
// Latency: each accepted word is written one cycle later; core release HOLD cycles after the last write.
// Backpressure: s_ready is high only while loading; s_valid low simply stalls the download.
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int AW   = 7,
  parameter int DW   = 32,
  parameter int HOLD = HOLD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [AW-1:0] load_base,
  input  logic [AW:0]   load_len,
  input  logic          run_en,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          core_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] ONE_WORD = (AW + 1)'(1);
  localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};

  state_t        state;
  logic [AW-1:0] addr_cnt;
  logic [AW:0]   word_cnt;
  logic          xfer;
  logic          last_xfer;
  logic          start_ok;
  logic          settle_tc;

  // A restart is only honoured when no download is in flight.
  assign start_ok  = load_start && !is_busy(state);
  assign xfer      = s_valid && s_ready;
  assign last_xfer = xfer && (word_cnt == ONE_WORD);

  assign s_ready    = (state == ST_LOAD);
  assign core_ready = (state == ST_RUN);
  assign busy       = is_busy(state);

  settle_counter #(
    .HOLD (HOLD)
  ) u_settle (
    .clk   (clk),
    .rst   (rst),
    .start (last_xfer),
    .en    (state == ST_SETTLE),
    .tc    (settle_tc)
  );

  // Main sequencing: HALT/RUN wait for work, LOAD takes words, SETTLE lets the last write land.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_HALT;
    end else begin
      case (state)
        ST_HALT: begin
          if (load_start)  state <= ST_LOAD;
          else if (run_en) state <= ST_RUN;
        end
        ST_LOAD: begin
          if (last_xfer) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_tc) state <= ST_RUN;
        end
        ST_RUN: begin
          // run_en low is deliberately not an exit; only a new download stops the core.
          if (load_start) state <= ST_LOAD;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  // Address and remaining-word counters; a zero length means a full RAM image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_cnt <= '0;
      word_cnt <= '0;
    end else if (start_ok) begin
      addr_cnt <= load_base;
      word_cnt <= (load_len == '0) ? FULL_LEN : load_len;
    end else if (xfer) begin
      addr_cnt <= addr_cnt + AW'(1);
      word_cnt <= word_cnt - ONE_WORD;
    end
  end

  // Registered RAM write port; data passes through untouched, the core does its own byte swap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_wen <= xfer;
      if (xfer) begin
        ram_addr  <= addr_cnt;
        ram_wdata <= s_data;
      end
    end
  end

  // done marks only the SETTLE->RUN handoff, never a direct run_en release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == ST_SETTLE) && settle_tc;
    end
  end

  // Sticky protocol error: a start request arriving mid-download; cleared by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (start_ok) begin
      err <= 1'b0;
    end else if (load_start && is_busy(state)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: doc/boot_loader_ctrl.md
BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: AW, 7, instruction RAM address width; DW, 32, instruction word width; HOLD, 2, settle cycles between the last write and core release.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 load_start  input  1  single-cycle request to begin a program download.
REQ-006 load_base  input  AW  first word address of the download, sampled when load_start is accepted.
REQ-007 load_len  input  AW+1  number of words to download, sampled when load_start is accepted; 0 means 2^AW.
REQ-008 run_en  input  1  level; releases the core from HALT without a download.
REQ-009 s_valid  input  1  download word valid.
REQ-010 s_data  input  DW  download word.
REQ-011 s_ready  output  1  loader can accept a word.
REQ-012 ram_wen  output  1  active-high write strobe to instruction RAM.
REQ-013 ram_addr  output  AW  instruction RAM word address.
REQ-014 ram_wdata  output  DW  instruction RAM write data.
REQ-015 core_ready  output  1  core run enable; 0 holds the core's PC at 0.
REQ-016 busy  output  1  high in LOAD or SETTLE.
REQ-017 done  output  1  one-cycle pulse on entry to RUN from SETTLE.
REQ-018 err  output  1  sticky protocol-error flag.

Function
REQ-019 FSM states SHALL be HALT, LOAD, SETTLE and RUN.
REQ-020 HALT transitions: load_start -> LOAD; else run_en -> RUN; load_start has priority.
REQ-021 RUN transitions: load_start -> LOAD; a low run_en does not leave RUN.
REQ-022 On load_start acceptance: addr_cnt <= load_base; word_cnt <= load_len (0 maps to 2^AW); err <= 0.
REQ-023 s_ready = 1 only in LOAD; a word is transferred when s_valid & s_ready in the same cycle.
REQ-024 Each transfer SHALL drive ram_wen=1, ram_addr=addr_cnt and ram_wdata=s_data, all registered, in the following cycle; ram_wen=0 in every other cycle.
REQ-025 addr_cnt SHALL increment modulo 2^AW per transfer (wrap 127 -> 0); word_cnt SHALL decrement per transfer.
REQ-026 The transfer that takes word_cnt to 0 SHALL move the FSM to SETTLE; s_ready SHALL be 0 in the next cycle.
REQ-027 SETTLE SHALL last exactly HOLD cycles, then enter RUN and pulse done for 1 cycle.
REQ-028 core_ready = 1 exactly when state is RUN; core_ready SHALL fall in the same cycle the FSM leaves RUN for LOAD.
REQ-029 load_start in LOAD or SETTLE SHALL be ignored (no restart) and SHALL set err.
REQ-030 s_valid while not in LOAD SHALL cause no write.
REQ-031 s_valid low in LOAD is a stall: no write, counters held, no timeout.
REQ-032 ram_wdata is passed through with no byte reordering; the core performs its own byte swap.

Reset
REQ-033 Reset asserted SHALL immediately force: state=HALT, addr_cnt=0, word_cnt=0, s_ready=0, ram_wen=0, ram_addr=0, ram_wdata=0, core_ready=0, busy=0, done=0, err=0.
REQ-034 Reset during LOAD SHALL abandon the download; any following write requires a new load_start.

Structure
REQ-035 The FSM state encoding and the HOLD default SHALL be in the shared chip package.
REQ-036 One sub-module SHALL be used: settle_counter, a HOLD-cycle down-counter with a terminal flag.

Verification
REQ-037 Reset, then load_start with base=0, len=3, words 0xA1,0xA2,0xA3 on back-to-back cycles -> writes to addresses 0,1,2, each one cycle after its transfer; core_ready=1 and done pulses 2 cycles after the last write strobe.
REQ-038 base=126, len=4 -> writes to addresses 126, 127, 0, 1.
REQ-039 len=3 with s_valid toggling 1,0,1,0,1 -> exactly 3 writes, no duplicates, addresses 0..2.
REQ-040 load_start during LOAD after 1 of 3 words -> err=1, download continues to 3 words; err clears on the next accepted load_start.
REQ-041 In RUN, load_start -> core_ready=0 in the same cycle; assert rst after 2 words -> all outputs at reset values and no further writes.
REQ-042 HALT with run_en=1 and no load -> RUN next cycle with core_ready=1 and no done pulse.
